// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: control-bundle bit positions and field widths.
package id_ex_stage_pkg;

  localparam int CTRL_W = 12;
  localparam int REG_W  = 5;

  localparam int CTRL_ALUOP2    = 11;
  localparam int CTRL_INVBRANCH = 10;
  localparam int CTRL_ZEROEXT   = 9;
  localparam int CTRL_REGDST    = 8;
  localparam int CTRL_ALUSRCB   = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_WRITEREG  = 5;
  localparam int CTRL_MEMWRITE  = 4;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_ALUOP1    = 2;
  localparam int CTRL_ALUOP0    = 1;
  localparam int CTRL_JUMP      = 0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: the ID instruction reads a register that the
// load currently in EX has not yet produced.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              ex_valid,
  input  logic              ex_memtoreg,
  input  logic [REG_W-1:0]  ex_rt,
  output logic              haz
);

  logic uses_rs;
  logic uses_rt;

  // Source usage and hazard; a load into $0 never blocks anything.
  always_comb begin
    uses_rs = id_valid & ~id_ctrl[CTRL_JUMP];
    uses_rt = id_valid & (id_ctrl[CTRL_REGDST] | id_ctrl[CTRL_BRANCH] | id_ctrl[CTRL_MEMWRITE]);
    haz     = ex_valid & ex_memtoreg & (ex_rt != '0) &
              ((uses_rs & (id_rs == ex_rt)) | (uses_rt & (id_rt == ex_rt)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches control and operands, extends the
// immediate, selects the destination, inserts bubbles on load-use hazards
// and flushes, and counts both events with saturating counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  output logic              stall_o,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_wreg,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              haz;
  logic [CTRL_W-1:0] ctrl_eff;
  logic [DATA_W-1:0] imm_ext;
  logic [REG_W-1:0]  wreg_sel;

  id_ex_stage_hazard_detect u_haz (
    .id_ctrl     (id_ctrl),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (ex_valid),
    .ex_memtoreg (ex_ctrl[CTRL_MEMTOREG]),
    .ex_rt       (ex_rt),
    .haz         (haz)
  );

  // Flush outranks the hazard, so a killed slot never also stalls upstream.
  assign stall_o = haz & ~flush & ~rst;

  // Immediate extension and destination select; invalid slots carry no control.
  always_comb begin
    ctrl_eff = id_valid ? id_ctrl : '0;
    if (id_ctrl[CTRL_ZEROEXT])
      imm_ext = {{(DATA_W-16){1'b0}}, id_imm};
    else
      imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};
    if (!ctrl_eff[CTRL_WRITEREG])
      wreg_sel = '0;
    else if (ctrl_eff[CTRL_REGDST])
      wreg_sel = id_rd;
    else
      wreg_sel = id_rt;
  end

  // Pipeline register: reset > flush > hazard bubble > normal latch.
  always_ff @(posedge clk) begin
    if (rst || flush || haz) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
      ex_pc4   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wreg  <= '0;
    end else begin
      ex_ctrl  <= ctrl_eff;
      ex_valid <= id_valid;
      ex_pc4   <= id_pc4;
      ex_a     <= id_rs_data;
      ex_b     <= id_rt_data;
      ex_imm   <= imm_ext;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_wreg  <= wreg_sel;
    end
  end

  // Saturating event counters; only one of them can move per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (haz) begin
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a scoreboard of expected EX-stage contents.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam logic [11:0] C_ADDI = 12'h0A0; // ALUSrcB|WriteReg
  localparam logic [11:0] C_ORI  = 12'h2A0; // + ZeroExt
  localparam logic [11:0] C_LW   = 12'h0E0; // ALUSrcB|MemToReg|WriteReg
  localparam logic [11:0] C_RT   = 12'h124; // RegDst|WriteReg|ALUop1
  localparam logic [11:0] C_J    = 12'h001; // Jump

  typedef struct {
    logic [11:0]       ctrl;
    logic              valid;
    logic [DATA_W-1:0] pc4, a, b, imm;
    logic [4:0]        rs, rt, wreg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [11:0] id_ctrl;
  logic id_valid;
  logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0] id_rs, id_rt, id_rd;
  logic flush;
  logic stall_o;
  logic [11:0] ex_ctrl;
  logic ex_valid;
  logic [DATA_W-1:0] ex_pc4, ex_a, ex_b, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  int exp_bub = 0;
  int exp_fl = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stall_o(stall_o), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .ex_pc4(ex_pc4), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, ".bubble_cnt"}, DATA_W'(bubble_cnt), DATA_W'(exp_bub > CMAX ? CMAX : exp_bub));
    chk({tag, ".flush_cnt"},  DATA_W'(flush_cnt),  DATA_W'(exp_fl  > CMAX ? CMAX : exp_fl));
  endtask

  // Drive one ID instruction, check stall before the edge, predict EX contents.
  task automatic step(input string tag, input logic [11:0] ctrl, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic fl, input logic exp_stall);
    exp_t e;
    id_ctrl    = ctrl;
    id_valid   = 1'b1;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_imm     = imm;
    id_pc4     = 32'h0040_0000 + {20'd0, imm[11:0]};
    id_rs_data = 32'h1000_0000 | {27'd0, rs};
    id_rt_data = 32'h2000_0000 | {27'd0, rt};
    flush      = fl;
    #1;
    chk({tag, ".stall_o"}, DATA_W'(stall_o), DATA_W'(exp_stall));
    if (fl || exp_stall) begin
      e = '{ctrl: '0, valid: 1'b0, pc4: '0, a: '0, b: '0, imm: '0, rs: '0, rt: '0, wreg: '0};
      if (fl) exp_fl++; else exp_bub++;
    end else begin
      e.ctrl  = ctrl;
      e.valid = 1'b1;
      e.pc4   = id_pc4;
      e.a     = id_rs_data;
      e.b     = id_rt_data;
      e.imm   = ctrl[9] ? {16'h0000, imm} : {{16{imm[15]}}, imm};
      e.rs    = rs;
      e.rt    = rt;
      e.wreg  = !ctrl[5] ? 5'd0 : (ctrl[8] ? rd : rt);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ex_ctrl"},  DATA_W'(ex_ctrl),  DATA_W'(e.ctrl));
      chk({tag, ".ex_valid"}, DATA_W'(ex_valid), DATA_W'(e.valid));
      chk({tag, ".ex_pc4"},   ex_pc4,            e.pc4);
      chk({tag, ".ex_a"},     ex_a,              e.a);
      chk({tag, ".ex_b"},     ex_b,              e.b);
      chk({tag, ".ex_imm"},   ex_imm,            e.imm);
      chk({tag, ".ex_rs"},    DATA_W'(ex_rs),    DATA_W'(e.rs));
      chk({tag, ".ex_rt"},    DATA_W'(ex_rt),    DATA_W'(e.rt));
      chk({tag, ".ex_wreg"},  DATA_W'(ex_wreg),  DATA_W'(e.wreg));
      chk_counters(tag);
    end
  endtask

  initial begin
    // Reset with live, hazard-looking inputs present.
    rst = 1'b1; flush = 1'b0; id_valid = 1'b1; id_ctrl = C_LW;
    id_pc4 = 32'h1234; id_rs_data = 32'hAAAA; id_rt_data = 32'hBBBB;
    id_imm = 16'h8001; id_rs = 5'd8; id_rt = 5'd8; id_rd = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stall_o",  DATA_W'(stall_o),  '0);
    chk("reset.ex_ctrl",  DATA_W'(ex_ctrl),  '0);
    chk("reset.ex_valid", DATA_W'(ex_valid), '0);
    chk("reset.ex_pc4",   ex_pc4,            '0);
    chk("reset.ex_a",     ex_a,              '0);
    chk("reset.ex_b",     ex_b,              '0);
    chk("reset.ex_imm",   ex_imm,            '0);
    chk("reset.ex_rs",    DATA_W'(ex_rs),    '0);
    chk("reset.ex_rt",    DATA_W'(ex_rt),    '0);
    chk("reset.ex_wreg",  DATA_W'(ex_wreg),  '0);
    chk_counters("reset");
    rst = 1'b0;

    // Pass-through and immediate extension.
    step("addi",  C_ADDI, 5'd3, 5'd5, 5'd9,  16'hFFF0, 1'b0, 1'b0);
    step("ori",   C_ORI,  5'd3, 5'd5, 5'd9,  16'hFFF0, 1'b0, 1'b0);

    // Load-use: one bubble, then the consumer latches.
    step("lw8",   C_LW,   5'd2, 5'd8, 5'd0,  16'h0004, 1'b0, 1'b0);
    step("use8",  C_RT,   5'd8, 5'd3, 5'd10, 16'h5020, 1'b0, 1'b1);
    step("use8r", C_RT,   5'd8, 5'd3, 5'd10, 16'h5020, 1'b0, 1'b0);

    // No false hazards.
    step("lw0",   C_LW,   5'd2, 5'd0, 5'd0,  16'h0008, 1'b0, 1'b0);
    step("use0",  C_RT,   5'd0, 5'd0, 5'd11, 16'h5820, 1'b0, 1'b0);
    step("lw8b",  C_LW,   5'd2, 5'd8, 5'd0,  16'h000C, 1'b0, 1'b0);
    step("jump",  C_J,    5'd8, 5'd8, 5'd8,  16'h4321, 1'b0, 1'b0);
    step("lw8c",  C_LW,   5'd2, 5'd8, 5'd0,  16'h0010, 1'b0, 1'b0);
    step("addi8", C_ADDI, 5'd4, 5'd8, 5'd7,  16'h0001, 1'b0, 1'b0);

    // Flush beats a coincident load-use hazard.
    step("lw8d",  C_LW,   5'd2, 5'd8, 5'd0,  16'h0014, 1'b0, 1'b0);
    step("flush", C_RT,   5'd8, 5'd3, 5'd10, 16'h5020, 1'b1, 1'b0);

    // Drive the bubble counter past all-ones.
    for (int i = 0; i < CMAX + 4; i++) begin
      step("sat_lw",  C_LW, 5'd2, 5'd8, 5'd0,  16'h0018, 1'b0, 1'b0);
      step("sat_use", C_RT, 5'd8, 5'd9, 5'd12, 16'h6020, 1'b0, 1'b1);
    end
    chk("sat.bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(CMAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
